// File: rtl/u8outwr.sv
// Output-side write responder: buffers Np-lane int8 result pushes and drains them to
// memory as 32-bit word writes with byte enables, splitting word-straddling lanes in two.
module u8outwr #(
  parameter int unsigned Np    = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             acvalid,
  input  logic [Np-1:0]    oen,
  input  logic [24*Np-1:0] out_adr,
  input  logic [2:0]       out_res,
  input  logic [32*Np-1:0] acc_data,
  output logic             out_rdy,
  output logic             m_we,
  output logic [21:0]      m_adr,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_be,
  input  logic             m_rdy,
  output logic             busy
);

  localparam int unsigned LW = (Np > 1) ? $clog2(Np) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned BW = 58;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LANE  = 2'd1;
  localparam logic [1:0] S_SPLIT = 2'd2;

  logic [Np-1:0]    mem_oen [DEPTH];
  logic [24*Np-1:0] mem_adr [DEPTH];
  logic [2:0]       mem_res [DEPTH];
  logic [32*Np-1:0] mem_dat [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0]   count;
  logic [1:0]    state, nstate;
  logic [LW-1:0] lane, nlane;
  logic          push, pop, adv, nx_avail, split_c;
  logic          n_we;
  logic [21:0]   n_adr;
  logic [31:0]   n_wd;
  logic [3:0]    n_be;

  logic [Np-1:0]    h_oen, x_oen;
  logic [24*Np-1:0] h_adr, x_adr;
  logic [2:0]       h_res, x_res;
  logic [32*Np-1:0] h_dat, x_dat;
  logic [LW:0]      fl_head, nl_head, fl_next;
  logic [BW-1:0]    bt_first, bt_a, bt_b, bt_nlane, bt_nx;

  // Lowest enabled lane at or above start; MSB flags that one was found.
  function automatic logic [LW:0] find_lane(input logic [Np-1:0] en, input int start);
    logic [LW:0] r;
    r = '0;
    for (int i = int'(Np) - 1; i >= 0; i--)
      if (en[i] && i >= start) r = {1'b1, LW'(i)};
    return r;
  endfunction

  function automatic logic [2:0] nbytes(input logic [2:0] res);
    return (res > 3'd3) ? 3'd4 : res + 3'd1;
  endfunction

  function automatic logic needs_split(input logic [23:0] adr, input logic [2:0] res);
    return ({1'b0, adr[1:0]} + nbytes(res)) > 3'd4;
  endfunction

  // Packs {word address, byte enables, write data} for beat A or beat B of one lane.
  function automatic logic [BW-1:0] make_beat(input logic [23:0] adr, input logic [2:0] res,
                                              input logic [31:0] data, input logic second);
    logic [1:0] o;
    logic [2:0] sh;
    logic [7:0] mask, ma;
    o    = adr[1:0];
    mask = 8'((9'd1 << nbytes(res)) - 9'd1);
    sh   = 3'd4 - {1'b0, o};
    if (!second) begin
      ma = mask << o;
      return {adr[23:2], ma[3:0], data << {o, 3'b000}};
    end
    ma = mask >> sh;
    return {22'(adr[23:2] + 22'd1), ma[3:0], data >> {sh, 3'b000}};
  endfunction

  assign out_rdy = (count != (PW+1)'(DEPTH));
  assign busy    = (count != '0) || m_we;
  assign push    = acvalid && out_rdy && (|oen);
  assign rd_nxt  = PW'(rd_ptr + 1'b1);

  assign h_oen = mem_oen[rd_ptr];
  assign h_adr = mem_adr[rd_ptr];
  assign h_res = mem_res[rd_ptr];
  assign h_dat = mem_dat[rd_ptr];

  // Entry following the head: stored one, or the incoming push when the head is the last.
  assign nx_avail = (count > (PW+1)'(1)) || push;
  assign x_oen = (count > (PW+1)'(1)) ? mem_oen[rd_nxt] : oen;
  assign x_adr = (count > (PW+1)'(1)) ? mem_adr[rd_nxt] : out_adr;
  assign x_res = (count > (PW+1)'(1)) ? mem_res[rd_nxt] : out_res;
  assign x_dat = (count > (PW+1)'(1)) ? mem_dat[rd_nxt] : acc_data;

  assign fl_head = find_lane(h_oen, 0);
  assign nl_head = find_lane(h_oen, int'(lane) + 1);
  assign fl_next = find_lane(x_oen, 0);

  assign split_c  = needs_split(h_adr[int'(lane)*24 +: 24], h_res);
  assign bt_a     = make_beat(h_adr[int'(lane)*24 +: 24], h_res, h_dat[int'(lane)*32 +: 32], 1'b0);
  assign bt_b     = make_beat(h_adr[int'(lane)*24 +: 24], h_res, h_dat[int'(lane)*32 +: 32], 1'b1);
  assign bt_first = make_beat(h_adr[int'(fl_head[LW-1:0])*24 +: 24], h_res,
                              h_dat[int'(fl_head[LW-1:0])*32 +: 32], 1'b0);
  assign bt_nlane = make_beat(h_adr[int'(nl_head[LW-1:0])*24 +: 24], h_res,
                              h_dat[int'(nl_head[LW-1:0])*32 +: 32], 1'b0);
  assign bt_nx    = make_beat(x_adr[int'(fl_next[LW-1:0])*24 +: 24], x_res,
                              x_dat[int'(fl_next[LW-1:0])*32 +: 32], 1'b0);

  // Next-state and next-beat selection; a new beat is loaded the same cycle one is accepted.
  always_comb begin
    nstate = state;
    nlane  = lane;
    n_we   = m_we;
    {n_adr, n_be, n_wd} = {m_adr, m_be, m_wdata};
    pop    = 1'b0;
    adv    = 1'b0;
    case (state)
      S_IDLE: if (count != '0) begin
        nlane  = fl_head[LW-1:0];
        n_we   = 1'b1;
        {n_adr, n_be, n_wd} = bt_first;
        nstate = S_LANE;
      end
      S_LANE: if (m_rdy) begin
        if (split_c) begin
          {n_adr, n_be, n_wd} = bt_b;
          nstate = S_SPLIT;
        end else begin
          adv = 1'b1;
        end
      end
      S_SPLIT: if (m_rdy) adv = 1'b1;
      default: begin
        nstate = S_IDLE;
        n_we   = 1'b0;
      end
    endcase
    if (adv) begin
      if (nl_head[LW]) begin
        nlane  = nl_head[LW-1:0];
        {n_adr, n_be, n_wd} = bt_nlane;
        nstate = S_LANE;
      end else begin
        pop = 1'b1;
        if (nx_avail) begin
          nlane  = fl_next[LW-1:0];
          {n_adr, n_be, n_wd} = bt_nx;
          nstate = S_LANE;
        end else begin
          n_we   = 1'b0;
          nstate = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state   <= S_IDLE;
      lane    <= '0;
      m_we    <= 1'b0;
      m_adr   <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= nstate;
      lane    <= nlane;
      m_we    <= n_we;
      m_adr   <= n_adr;
      m_wdata <= n_wd;
      m_be    <= n_be;
      if (push) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= (PW+1)'(count + 1'b1);
        2'b01:   count <= (PW+1)'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (arst_n && push) begin
      mem_oen[wr_ptr] <= oen;
      mem_adr[wr_ptr] <= out_adr;
      mem_res[wr_ptr] <= out_res;
      mem_dat[wr_ptr] <= acc_data;
    end
  end

endmodule

// File: tb/tb_u8outwr.sv
// Directed bench for u8outwr (Np=4, DEPTH=4): alignment, splits, lane skipping,
// backpressure, push-at-pop and mid-drain reset.
module tb_u8outwr;

  logic         aclk = 1'b0;
  logic         arst_n;
  logic         acvalid;
  logic [3:0]   oen;
  logic [95:0]  out_adr;
  logic [2:0]   out_res;
  logic [127:0] acc_data;
  logic         out_rdy;
  logic         m_we;
  logic [21:0]  m_adr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_be;
  logic         m_rdy;
  logic         busy;

  int checks = 0;
  int errors = 0;

  u8outwr #(.Np(4), .DEPTH(4)) u_dut (
    .aclk     (aclk),
    .arst_n   (arst_n),
    .acvalid  (acvalid),
    .oen      (oen),
    .out_adr  (out_adr),
    .out_res  (out_res),
    .acc_data (acc_data),
    .out_rdy  (out_rdy),
    .m_we     (m_we),
    .m_adr    (m_adr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_rdy    (m_rdy),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [21:0] adr, input logic [3:0] be,
                          input logic [31:0] wd);
    chk({tag, ".we"}, 32'(m_we), 32'd1);
    chk({tag, ".adr"}, 32'(m_adr), 32'(adr));
    chk({tag, ".be"}, 32'(m_be), 32'(be));
    chk({tag, ".wd"}, m_wdata, wd);
  endtask

  task automatic push1(input logic [23:0] adr, input logic [2:0] res, input logic [31:0] d);
    acvalid  = 1'b1;
    oen      = 4'b0001;
    out_adr  = {72'h0, adr};
    out_res  = res;
    acc_data = {96'h0, d};
  endtask

  initial begin
    arst_n = 1'b0; acvalid = 1'b0; oen = '0; out_adr = '0; out_res = '0;
    acc_data = '0; m_rdy = 1'b1;
    step(); step();
    arst_n = 1'b1;
    chk("rst.we", 32'(m_we), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.rdy", 32'(out_rdy), 1);
    chk("rst.adr", 32'(m_adr), 0);
    chk("rst.be", 32'(m_be), 0);
    chk("rst.wd", m_wdata, 0);

    // Aligned full word
    push1(24'h000010, 3'd3, 32'h44332211);
    step(); acvalid = 1'b0;
    chk("t1.busy_q", 32'(busy), 1);
    chk("t1.we_q", 32'(m_we), 0);
    step(); chk_beat("t1", 22'h4, 4'hF, 32'h44332211);
    step();
    chk("t1.we_end", 32'(m_we), 0);
    chk("t1.busy_end", 32'(busy), 0);

    // Straddling write splits into two beats
    push1(24'h000013, 3'd2, 32'h00CCBBAA);
    step(); acvalid = 1'b0;
    step(); chk_beat("t2a", 22'h4, 4'h8, 32'hAA000000);
    step(); chk_beat("t2b", 22'h5, 4'h3, 32'h0000CCBB);
    step(); chk("t2.we_end", 32'(m_we), 0);

    // Four lanes, lane 2 disabled
    acvalid  = 1'b1; oen = 4'b1011; out_res = 3'd3;
    out_adr  = {24'h00010C, 24'h000108, 24'h000104, 24'h000100};
    acc_data = {32'h33323130, 32'h23222120, 32'h13121110, 32'h03020100};
    step(); acvalid = 1'b0;
    step(); chk_beat("t3l0", 22'h40, 4'hF, 32'h03020100);
    step(); chk_beat("t3l1", 22'h41, 4'hF, 32'h13121110);
    step(); chk_beat("t3l3", 22'h43, 4'hF, 32'h33323130);
    step(); chk("t3.we_end", 32'(m_we), 0);

    // Backpressure: fill FIFO, fifth push held off, then drain in order
    m_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push1(24'(24'h000200 + 4 * k), 3'd3, 32'(32'hD0 + k));
      step();
    end
    chk("t4.rdy_full", 32'(out_rdy), 0);
    push1(24'h000210, 3'd3, 32'hD4);
    step();
    chk("t4.rdy_held", 32'(out_rdy), 0);
    chk_beat("t4.hold0", 22'h80, 4'hF, 32'hD0);
    step();
    chk_beat("t4.hold1", 22'h80, 4'hF, 32'hD0);
    m_rdy = 1'b1;
    step();
    chk_beat("t4.e1", 22'h81, 4'hF, 32'hD1);
    chk("t4.rdy_open", 32'(out_rdy), 1);
    step(); acvalid = 1'b0;
    chk_beat("t4.e2", 22'h82, 4'hF, 32'hD2);
    step(); chk_beat("t4.e3", 22'h83, 4'hF, 32'hD3);
    step(); chk_beat("t4.e4", 22'h84, 4'hF, 32'hD4);
    step();
    chk("t4.we_end", 32'(m_we), 0);
    chk("t4.busy_end", 32'(busy), 0);

    // Push in the same cycle the only entry's final beat is accepted
    push1(24'h000300, 3'd3, 32'hF0F0F0F0);
    step(); acvalid = 1'b0;
    step(); chk_beat("t5.f0", 22'hC0, 4'hF, 32'hF0F0F0F0);
    push1(24'h000304, 3'd0, 32'h000000F1);
    step(); acvalid = 1'b0;
    chk_beat("t5.f1", 22'hC1, 4'h1, 32'h000000F1);
    chk("t5.busy", 32'(busy), 1);
    step(); chk("t5.we_end", 32'(m_we), 0);

    // Reset during the split beat, then a push with no lanes enabled
    push1(24'h000013, 3'd2, 32'h00CCBBAA);
    step(); acvalid = 1'b0;
    step(); step();
    chk_beat("t6.split", 22'h5, 4'h3, 32'h0000CCBB);
    arst_n = 1'b0;
    step(); arst_n = 1'b1;
    chk("t6.we", 32'(m_we), 0);
    chk("t6.busy", 32'(busy), 0);
    chk("t6.rdy", 32'(out_rdy), 1);
    acvalid = 1'b1; oen = 4'b0000;
    step(); acvalid = 1'b0;
    chk("t6.busy_noen", 32'(busy), 0);
    step();
    chk("t6.we_noen", 32'(m_we), 0);
    step();
    chk("t6.we_noen2", 32'(m_we), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
